spi_mult_frame_engine: RTL and testbench

- Downstream consumer of the SPI slave stage (`spi_master_slave`) in the multiplier_UART_SPI design; also drives that stage's transmit side.
- Takes received SPI bytes (`output_reg_data` / `rx_valid`) as operand A, then operand B.
- Multiplies them with a sequential shift-add unit.
- Returns the 2*DATA_W-bit product MSB-byte first through the SPI slave's `slave_tx_start` / `input_reg_data` / `tx_done` handshake.

---
 rtl/spi_mult_frame_engine.sv | 170 +++++++++++++++++
 tb/tb_spi_mult_frame_engine.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/spi_mult_frame_engine.sv
// SPI operand/product frame engine: receives operand A then B from the SPI
// slave, multiplies them with a shift-add unit and streams the product back
// MSB byte first over the slave's transmit handshake.
module spi_mult_frame_engine #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                tx_done,
  output logic                tx_start,
  output logic [DATA_W-1:0]   tx_data,
  output logic [2*DATA_W-1:0] result,
  output logic                result_valid,
  output logic                busy,
  output logic                overrun,
  output logic                timeout
);

  localparam int PW = 2*DATA_W;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_B, S_MULT, S_SEND_HI, S_SEND_LO
  } state_t;

  state_t          state, state_nxt;
  logic            rx_prev, tx_prev;
  logic            rx_evt, tx_evt;
  logic [PW-1:0]   mcand, acc, acc_sum;
  logic [DATA_W-1:0] mplier;
  logic [BW-1:0]   bit_cnt;
  logic [TW-1:0]   to_cnt, to_cnt_inc;
  logic            cap_a, cap_b, to_inc, to_fire, step, fin, load_lo, drop;

  // Strobes may be level-held; only rising edges are events. A tx_done edge
  // coincident with our own tx_start belongs to the previous byte, so mask it.
  assign rx_evt     = rx_valid & ~rx_prev;
  assign tx_evt     = tx_done & ~tx_prev & ~tx_start;
  assign acc_sum    = acc + (mplier[0] ? mcand : '0);
  assign to_cnt_inc = to_cnt + 1'b1;
  assign busy       = (state != S_IDLE);

  // Edge-history registers, running in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_prev <= 1'b0;
      tx_prev <= 1'b0;
    end else begin
      rx_prev <= rx_valid;
      tx_prev <= tx_done;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath control decode
  always_comb begin
    state_nxt = state;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    to_inc    = 1'b0;
    to_fire   = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    load_lo   = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_evt) begin
          cap_a     = 1'b1;
          state_nxt = S_GET_B;
        end
      end
      S_GET_B: begin
        // An arriving byte beats an expiring count in the same cycle
        if (rx_evt) begin
          cap_b     = 1'b1;
          state_nxt = S_MULT;
        end else if (to_cnt_inc == TO_LAST) begin
          to_fire   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          to_inc    = 1'b1;
        end
      end
      S_MULT: begin
        step = 1'b1;
        drop = rx_evt;
        if (bit_cnt == BIT_LAST) begin
          fin       = 1'b1;
          state_nxt = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        drop = rx_evt;
        if (tx_evt) begin
          load_lo   = 1'b1;
          state_nxt = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        // A byte landing as we return to IDLE is still a dropped byte
        drop = rx_evt;
        if (tx_evt) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand, shift-add accumulator, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      bit_cnt      <= '0;
      to_cnt       <= '0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      tx_start     <= 1'b0;
      result_valid <= 1'b0;
      timeout      <= to_fire;
      if (cap_a) begin
        mcand   <= PW'(rx_data);
        to_cnt  <= '0;
        overrun <= 1'b0;
      end
      if (to_inc)  to_cnt <= to_cnt_inc;
      if (to_fire) mcand  <= '0;
      if (cap_b) begin
        mplier  <= rx_data;
        acc     <= '0;
        bit_cnt <= '0;
      end
      if (step) begin
        acc     <= acc_sum;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fin) begin
        result       <= acc_sum;
        result_valid <= 1'b1;
        tx_data      <= acc_sum[PW-1:DATA_W];
        tx_start     <= 1'b1;
      end
      if (load_lo) begin
        tx_data  <= acc[DATA_W-1:0];
        tx_start <= 1'b1;
      end
      if (drop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_mult_frame_engine.sv
// Directed bench for spi_mult_frame_engine with hand-computed products.
module tb_spi_mult_frame_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        overrun;
  logic        timeout;

  int n_chk = 0;
  int n_bad = 0;

  spi_mult_frame_engine #(.DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data),
    .result(result), .result_valid(result_valid), .busy(busy),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs move 1 time unit after the rising edge, well away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe rx_valid for 'hold' edges, then one low edge so the next byte is a fresh edge
  task automatic send_byte(input logic [7:0] d, input int hold);
    rx_data  = d;
    rx_valid = 1'b1;
    repeat (hold) tick();
    rx_valid = 1'b0;
    tick();
  endtask

  // Hold tx_done for 'hold' edges and report any tx_start seen meanwhile
  task automatic pulse_done(input int hold, output logic got, output logic [7:0] b);
    got     = 1'b0;
    b       = 8'h00;
    tx_done = 1'b1;
    for (int i = 0; i < hold + 4; i++) begin
      tick();
      if (i == hold - 1) tx_done = 1'b0;
      if (tx_start && !got) begin
        got = 1'b1;
        b   = tx_data;
      end
    end
  endtask

  // One full frame: A, B, product, two transmitted bytes
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input int hold,
                           input int tx_hold, input bit early, input bit inj,
                           input logic [15:0] exp, input string nm);
    int          idx;
    logic        got;
    logic [7:0]  lo;
    send_byte(a, hold);
    chk({nm, "_ovr_clr"}, overrun, 1'b0);
    chk({nm, "_busy_b"}, busy, 1'b1);
    send_byte(b, hold);
    // B-capture edge is edge 0; send_byte leaves us just after edge 'hold'
    idx = hold;
    while (!result_valid && idx < 40) begin
      tick();
      idx++;
    end
    chk({nm, "_lat"}, idx, 8);
    chk({nm, "_res"}, result, exp);
    chk({nm, "_txs_hi"}, tx_start, 1'b1);
    chk({nm, "_hi"}, tx_data, exp[15:8]);
    if (early) begin
      // tx_done rising during our own tx_start must not count
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk({nm, "_early_ign"}, tx_start, 1'b0);
    end else begin
      tick();
      chk({nm, "_rv_pulse"}, result_valid, 1'b0);
    end
    if (inj) begin
      send_byte(8'h55, 1);
      chk({nm, "_ovr_set"}, overrun, 1'b1);
    end
    repeat (19) tick();
    pulse_done(tx_hold, got, lo);
    chk({nm, "_lo_got"}, got, 1'b1);
    chk({nm, "_lo"}, lo, exp[7:0]);
    repeat (19) tick();
    pulse_done(tx_hold, got, lo);
    chk({nm, "_no_extra_tx"}, got, 1'b0);
    chk({nm, "_busy_end"}, busy, 1'b0);
    chk({nm, "_res_end"}, result, exp);
    chk({nm, "_ovr_end"}, overrun, inj);
  endtask

  initial begin
    int   idx;
    int   nstart;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_done  = 1'b0;
    repeat (3) tick();
    chk("rst_txs", tx_start, 1'b0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_res", result, 16'h0000);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_to", timeout, 1'b0);
    reset = 1'b0;
    tick();

    run_frame(8'h0C, 8'h0B, 1, 1, 1'b0, 1'b0, 16'h0084, "f0c0b");
    run_frame(8'hFF, 8'hFF, 5, 3, 1'b0, 1'b0, 16'hFE01, "fffff");
    run_frame(8'h00, 8'hA5, 1, 1, 1'b1, 1'b0, 16'h0000, "f00a5");
    run_frame(8'h01, 8'h80, 1, 1, 1'b0, 1'b0, 16'h0080, "f0180");
    run_frame(8'h5A, 8'h3C, 2, 1, 1'b0, 1'b0, 16'h1518, "f5a3c");

    // Abandoned frame: expiry 15 edges after the A-capture edge
    send_byte(8'h12, 1);
    idx = 1;
    while (!timeout && idx < 40) begin
      tick();
      idx++;
    end
    chk("to_edge", idx, 15);
    chk("to_busy", busy, 1'b0);
    tick();
    chk("to_pulse", timeout, 1'b0);
    run_frame(8'h03, 8'h04, 1, 1, 1'b0, 1'b0, 16'h000C, "f0304");

    // Stray byte during SEND_HI sets overrun; next A clears it
    run_frame(8'h0C, 8'h0B, 1, 1, 1'b0, 1'b1, 16'h0084, "fovr");
    run_frame(8'h02, 8'h09, 1, 1, 1'b0, 1'b0, 16'h0012, "f0209");

    // Reset in the middle of MULT abandons the frame
    send_byte(8'h09, 1);
    send_byte(8'h05, 1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("mrst_txs", tx_start, 1'b0);
    chk("mrst_txd", tx_data, 8'h00);
    chk("mrst_res", result, 16'h0000);
    chk("mrst_rv", result_valid, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ovr", overrun, 1'b0);
    chk("mrst_to", timeout, 1'b0);
    reset  = 1'b0;
    nstart = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tx_start) nstart++;
    end
    chk("mrst_no_txs", nstart, 0);
    run_frame(8'h07, 8'h06, 1, 1, 1'b0, 1'b0, 16'h002A, "f0706");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
